dimm_cmd_sequencer: RTL and testbench
=====================================

Name: dimm_cmd_sequencer

Overview:
Closed-page DDR5 command sequencer between the memory-controller request queue and the DIMM command bus. Accepts one request (read, write or instruction fetch) through a valid/ready handshake and decodes the 36-bit address into channel/bank-group/bank/row/column. Issues the ACT0, ACT1, RD0/WR0, RD1/WR1 and PRE sequence, enforcing tRCD, tRAS, CL/CWL+burst and tRP with internal counters. Handles one request at a time; the queue drains into it.

Parameters:
T_RCD, 39, cycles from ACT0 to RD0/WR0 (min 2)
T_RAS, 76, min cycles from ACT0 to PRE
T_CL, 40, read CAS latency, cycles from RD0
T_CWL, 38, write CAS latency, cycles from WR0
T_BURST, 8, data burst cycles after CAS latency
T_RP, 39, cycles from PRE until next request accepted (min 1)

Ports:
clk  in  1  clock (all timing in clk cycles)
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  queue head holds a request
req_ready  out  1  sequencer can accept a request
req_oper  in  2  0=read, 1=write, 2=instruction fetch, 3=illegal
req_addr  in  36  physical address
cmd_valid  out  1  command present this cycle
cmd_type  out  3  command encoding (package enum)
cmd_channel  out  1  req_addr[6]
cmd_bg  out  3  req_addr[9:7]
cmd_bank  out  2  req_addr[11:10]
cmd_row  out  16  req_addr[33:18]
cmd_col  out  6  req_addr[17:12]
done  out  1  one-cycle pulse, coincident with PRE
err_oper  out  1  one-cycle pulse on illegal operation

Behaviour:
- Reset values: req_ready=1, cmd_valid=0, cmd_type=NOP, all cmd field outputs 0, done=0, err_oper=0, FSM=IDLE, counters 0.
- Handshake at cycle h when req_valid && req_ready. Oper and decoded fields are registered at h. req_ready is 0 from h+1 until re-entering IDLE.
- Address bits 35:34 and 5:0 are ignored. Oper 2 is treated exactly as a read.
- States: IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP.
- Sequence timing:
  - ACT0 at h+1, ACT1 at h+2.
  - CAS0 (RD0/WR0) at c = h+1+T_RCD; CAS1 (RD1/WR1) at c+1.
  - PRE at p = max(h+1+T_RAS, c+LAT), where LAT = T_CL+T_BURST for read/fetch and T_CWL+T_BURST for write.
  - req_ready returns to 1 at p+T_RP; a new handshake is possible in that cycle.
- Outputs during the sequence:
  - cmd_valid=1 only in ACT0/ACT1/CAS0/CAS1/PRE cycles; cmd_type=NOP otherwise.
  - cmd field outputs hold the registered request's fields from h+1 until the next handshake.
- Counters: one countdown counter for the current phase, plus an independent tRAS counter loaded at ACT0. WAIT_PRE exits only when both have expired. Counters are 8 bits wide; all parameters must be in 1..255 (elaboration assertion).
- Illegal oper (3): still accepted; err_oper pulses at h+1; no commands are issued; req_ready=1 again at h+2.
- req_valid deasserting while req_ready=0 has no effect. Request inputs are sampled only at the handshake.
- Reset mid-sequence: outputs return to reset values immediately (asynchronously). The in-flight sequence is abandoned and no PRE is issued. FSM returns to IDLE.
- done and err_oper never pulse in the same cycle.

Decomposition:
- Package dimm_pkg contains:
  - cmd_type_e: NOP=0, ACT0=1, ACT1=2, RD0=3, RD1=4, WR0=5, WR1=6, PRE=7
  - oper_e: READ=0, WRITE=1, IFETCH=2
  - field bit-position constants (CH_BIT=6, BG_LSB=7, BA_LSB=10, COL_LSB=12, ROW_LSB=18)
  - packed struct dimm_addr_t
- Sub-module dimm_timer: 8-bit loadable countdown with load/value/expired ports, instantiated twice (phase counter and tRAS counter).

Test Plan:
- Read with defaults, addr=0x0_1234_5A80, h=10: ACT0 cycle 11; RD0 cycle 50; RD1 cycle 51; PRE+done cycle 98; req_ready=1 at cycle 137. Fields: ch=0, bg=5, bank=2, col=0x05, row=0x048D.
- Write with defaults, same addr, h=10: WR0 cycle 50; PRE cycle 96; req_ready=1 at cycle 135.
- tRAS-dominated read, T_RAS=120, h=0: PRE at cycle 121, not 88; ready at cycle 160.
- Back-to-back reads with req_valid held: second ACT0 exactly one cycle after req_ready re-asserts; no cmd_valid while in WAIT_RP.
- Illegal oper=3, h=5: err_oper pulse at cycle 6; cmd_valid stays 0; req_ready=1 at cycle 7.
- rst_n low for 1 cycle at cycle 30 of a read: cmd_valid=0 and req_ready=1 immediately; no PRE/done issued; a subsequent read completes normally.

Source files
------------

// File: rtl/dimm_pkg.sv
// dimm_pkg: shared types and constants for the DDR5 closed-page command sequencer.
//   cmd_type_e  - DIMM command bus encoding
//   oper_e      - request operation codes (code 3 is illegal)
//   dimm_addr_t - decoded address fields
//   decode_addr - physical address to channel/bank-group/bank/row/column
package dimm_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT0 = 3'd1,
    ACT1 = 3'd2,
    RD0  = 3'd3,
    RD1  = 3'd4,
    WR0  = 3'd5,
    WR1  = 3'd6,
    PRE  = 3'd7
  } cmd_type_e;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } oper_e;

  localparam int CH_BIT  = 6;
  localparam int BG_LSB  = 7;
  localparam int BA_LSB  = 10;
  localparam int COL_LSB = 12;
  localparam int ROW_LSB = 18;

  typedef struct packed {
    logic [15:0] row;
    logic [5:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        ch;
  } dimm_addr_t;

  // Bits 35:34 and 5:0 carry no DIMM routing information.
  function automatic dimm_addr_t decode_addr(input logic [35:0] addr);
    dimm_addr_t d;
    logic       unused_bits;
    unused_bits = ^{addr[35:34], addr[5:0]};
    d.ch   = addr[CH_BIT];
    d.bg   = addr[BG_LSB +: 3];
    d.bank = addr[BA_LSB +: 2];
    d.col  = addr[COL_LSB +: 6];
    d.row  = addr[ROW_LSB +: 16];
    return d;
  endfunction

endpackage

// File: rtl/dimm_timer.sv
// dimm_timer: 8-bit loadable down-counter that stops at zero.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - value to load
//   value       - current count
//   expired     - count has reached zero
module dimm_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 8'd0;
    end else if (load) begin
      value <= load_value;
    end else if (value != 8'd0) begin
      value <= value - 8'd1;
    end
  end

  assign expired = (value == 8'd0);

endmodule

// File: rtl/dimm_cmd_sequencer.sv
// dimm_cmd_sequencer: closed-page DDR5 command sequencer, one request at a time.
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_valid/req_ready  - request handshake from the controller queue
//   req_oper, req_addr   - operation (0 rd, 1 wr, 2 ifetch, 3 illegal) and address
//   cmd_valid, cmd_type  - command bus strobe and encoding (cmd_type_e)
//   cmd_channel..cmd_col - decoded fields of the accepted request
//   done                 - pulse coincident with PRE
//   err_oper             - pulse the cycle after an illegal request is accepted
//
// state      | meaning
// S_IDLE     | ready for a request
// S_ACT0     | issue ACT0, start tRAS counter
// S_ACT1     | issue ACT1, start tRCD countdown
// S_WAIT_RCD | wait for tRCD
// S_CAS0     | issue RD0/WR0, start CAS latency + burst countdown
// S_CAS1     | issue RD1/WR1
// S_WAIT_PRE | wait until both latency and tRAS have expired
// S_PRE      | issue PRE, pulse done, start tRP countdown
// S_WAIT_RP  | wait for tRP (also the one-cycle recovery after an illegal request)
module dimm_cmd_sequencer
  import dimm_pkg::*;
#(
  parameter int T_RCD   = 39,
  parameter int T_RAS   = 76,
  parameter int T_CL    = 40,
  parameter int T_CWL   = 38,
  parameter int T_BURST = 8,
  parameter int T_RP    = 39
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_oper,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        done,
  output logic        err_oper
);

  localparam int LAT_RD = T_CL + T_BURST;
  localparam int LAT_WR = T_CWL + T_BURST;

  if (T_RCD < 2 || T_RCD > 255 || T_RAS < 1 || T_RAS > 255 ||
      T_CL < 1 || T_CL > 255 || T_CWL < 1 || T_CWL > 255 ||
      T_BURST < 1 || T_BURST > 255 || T_RP < 1 || T_RP > 255 ||
      LAT_RD > 257 || LAT_WR > 257) begin : g_bad_param
    $error("dimm_cmd_sequencer: timing parameter out of range");
  end

  // A timer loaded at the end of cycle x reads L in cycle x+1 and expires in
  // x+1+L; a wait state seeing expiry moves on one cycle later. The load values
  // below are the phase lengths minus that fixed pipeline offset.
  localparam logic [7:0] RCD_LD = 8'((T_RCD >= 3) ? T_RCD - 3 : 0);
  localparam logic [7:0] RAS_LD = 8'((T_RAS >= 2) ? T_RAS - 2 : 0);
  localparam logic [7:0] RD_LD  = 8'(LAT_RD - 2);
  localparam logic [7:0] WR_LD  = 8'(LAT_WR - 2);
  localparam logic [7:0] RP_LD  = 8'((T_RP >= 2) ? T_RP - 2 : 0);
  localparam bit         RCD_WAIT = (T_RCD >= 3);
  localparam bit         RP_WAIT  = (T_RP >= 2);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_e;

  state_e     state, state_nxt;
  dimm_addr_t fld_q;
  logic       is_wr_q;
  logic       err_q;
  cmd_type_e  cmd_nxt;
  logic       hs, illegal;
  logic       ph_load, ras_load;
  logic [7:0] ph_load_value;
  logic [7:0] ph_value, ras_value;
  logic       ph_expired, ras_expired;
  logic       unused_values;

  assign hs      = req_valid && req_ready;
  assign illegal = (req_oper == 2'd3);

  dimm_timer u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ph_load),
    .load_value (ph_load_value),
    .value      (ph_value),
    .expired    (ph_expired)
  );

  dimm_timer u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ras_load),
    .load_value (RAS_LD),
    .value      (ras_value),
    .expired    (ras_expired)
  );

  assign unused_values = ^{ph_value, ras_value};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      fld_q   <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= hs && illegal;
      if (hs) begin
        fld_q   <= decode_addr(req_addr);
        is_wr_q <= (req_oper == WRITE);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = NOP;
    ph_load       = 1'b0;
    ph_load_value = 8'd0;
    ras_load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hs) begin
          if (illegal) begin
            // Zero-length recovery: WAIT_RP for exactly one cycle.
            ph_load   = 1'b1;
            state_nxt = S_WAIT_RP;
          end else begin
            state_nxt = S_ACT0;
          end
        end
      end
      S_ACT0: begin
        cmd_nxt   = ACT0;
        ras_load  = 1'b1;
        state_nxt = S_ACT1;
      end
      S_ACT1: begin
        cmd_nxt = ACT1;
        if (RCD_WAIT) begin
          ph_load       = 1'b1;
          ph_load_value = RCD_LD;
          state_nxt     = S_WAIT_RCD;
        end else begin
          state_nxt = S_CAS0;
        end
      end
      S_WAIT_RCD: begin
        if (ph_expired) state_nxt = S_CAS0;
      end
      S_CAS0: begin
        cmd_nxt       = is_wr_q ? WR0 : RD0;
        ph_load       = 1'b1;
        ph_load_value = is_wr_q ? WR_LD : RD_LD;
        state_nxt     = S_CAS1;
      end
      S_CAS1: begin
        cmd_nxt   = is_wr_q ? WR1 : RD1;
        // Minimal latency (2) lets PRE follow CAS1 directly.
        state_nxt = (ph_expired && ras_expired) ? S_PRE : S_WAIT_PRE;
      end
      S_WAIT_PRE: begin
        if (ph_expired && ras_expired) state_nxt = S_PRE;
      end
      S_PRE: begin
        cmd_nxt = PRE;
        if (RP_WAIT) begin
          ph_load       = 1'b1;
          ph_load_value = RP_LD;
          state_nxt     = S_WAIT_RP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT_RP: begin
        if (ph_expired) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready   = (state == S_IDLE);
  assign cmd_valid   = (cmd_nxt != NOP);
  assign cmd_type    = cmd_nxt;
  assign done        = (state == S_PRE);
  assign err_oper    = err_q;
  assign cmd_channel = fld_q.ch;
  assign cmd_bg      = fld_q.bg;
  assign cmd_bank    = fld_q.bank;
  assign cmd_row     = fld_q.row;
  assign cmd_col     = fld_q.col;

endmodule

// File: tb/tb_dimm_cmd_sequencer.sv
// tb_dimm_cmd_sequencer: randomized self-checking bench for dimm_cmd_sequencer.
// A second instance with T_RAS=120 covers the tRAS-dominated case.
module tb_dimm_cmd_sequencer;

  localparam int T_RCD = 39, T_RAS = 76, T_CL = 40, T_CWL = 38, T_BURST = 8, T_RP = 39;
  localparam int T_RAS2 = 120;
  localparam int NREC = 400;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3,
                         C_RD1 = 3'd4, C_WR0 = 3'd5, C_WR1 = 3'd6, C_PRE = 3'd7;
  localparam logic [34:0] RESET_OBS = {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 28'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic [1:0]  req_oper = 2'd0;
  logic [35:0] req_addr = 36'd0;

  logic        rdy0, cv0, ch0, done0, err0;
  logic [2:0]  ty0, bg0;
  logic [1:0]  ba0;
  logic [15:0] row0;
  logic [5:0]  col0;
  logic        rdy1, cv1, ch1, done1, err1;
  logic [2:0]  ty1, bg1;
  logic [1:0]  ba1;
  logic [15:0] row1;
  logic [5:0]  col1;

  // Observation word: {ready, cmd_valid, cmd_type, done, err_oper, row, col, bank, bg, ch}
  logic [34:0] obs0, obs1;
  assign obs0 = {rdy0, cv0, ty0, done0, err0, row0, col0, ba0, bg0, ch0};
  assign obs1 = {rdy1, cv1, ty1, done1, err1, row1, col1, ba1, bg1, ch1};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [34:0] rec_obs [NREC];

  dimm_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
    .req_oper(req_oper), .req_addr(req_addr), .cmd_valid(cv0), .cmd_type(ty0),
    .cmd_channel(ch0), .cmd_bg(bg0), .cmd_bank(ba0), .cmd_row(row0), .cmd_col(col0),
    .done(done0), .err_oper(err0)
  );

  dimm_cmd_sequencer #(.T_RAS(T_RAS2)) dut_ras (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(rdy1),
    .req_oper(req_oper), .req_addr(req_addr), .cmd_valid(cv1), .cmd_type(ty1),
    .cmd_channel(ch1), .cmd_bg(bg1), .cmd_bank(ba1), .cmd_row(row1), .cmd_col(col1),
    .done(done1), .err_oper(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (offsets relative to handshake cycle) ----------------
  function automatic logic [27:0] spec_fields(input logic [35:0] a);
    return {a[33:18], a[17:12], a[11:10], a[9:7], a[6]};
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    return (op == 2'd1) ? T_CWL + T_BURST : T_CL + T_BURST;
  endfunction

  function automatic int pre_off(input logic [1:0] op, input int tras);
    int a, b;
    a = 1 + tras;
    b = 1 + T_RCD + lat_of(op);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] exp_type(input logic [1:0] op, input int tras, input int k);
    int c;
    c = 1 + T_RCD;
    if (k == 1) return C_ACT0;
    if (k == 2) return C_ACT1;
    if (k == c) return (op == 2'd1) ? C_WR0 : C_RD0;
    if (k == c + 1) return (op == 2'd1) ? C_WR1 : C_RD1;
    if (k == pre_off(op, tras)) return C_PRE;
    return C_NOP;
  endfunction

  function automatic logic [34:0] exp_obs(input logic [1:0] op, input int tras,
                                          input logic [27:0] f, input int k);
    logic [2:0] t;
    logic r, v, d;
    int p;
    t = exp_type(op, tras, k);
    p = pre_off(op, tras);
    r = (k >= p + T_RP);
    v = (t != C_NOP);
    d = (k == p);
    return {r, v, t, d, 1'b0, f};
  endfunction

  // ---------------- stimulus / recording ----------------
  task automatic start_req(input int which, input logic [1:0] op, input logic [35:0] a,
                           output int h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((which == 0) ? rdy0 : rdy1) begin
        ok = 1'b1;
        break;
      end
    end
    h = cyc;
    req_oper = op;
    req_addr = a;
    if (which == 0) req_valid = 1'b1;
    else req_valid2 = 1'b1;
  endtask

  task automatic watch(input int which, input int n, input int drop_at, input bit swap,
                       input logic [1:0] op_n, input logic [35:0] a_n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_obs[k] = (which == 0) ? obs0 : obs1;
      if (k == 1 && swap) begin
        req_oper = op_n;
        req_addr = a_n;
      end
      if (k == drop_at) begin
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
        req_oper   = 2'($urandom_range(0, 3));
        req_addr   = {4'($urandom), $urandom};
      end
    end
  endtask

  function automatic logic [35:0] rand_addr();
    return {4'($urandom), $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs0 !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_state dut: got %h want %h", obs0, RESET_OBS);
    end
    n_checks++;
    if (obs1 !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_state dut_ras: got %h want %h", obs1, RESET_OBS);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_default(input logic [1:0] op, input int pre_lit, input int rdy_lit);
    logic [35:0] a;
    logic [27:0] f;
    int h, r, pd, rd;
    bit ok;
    a = 36'h0_1234_5A80;
    f = {16'h048D, 6'h05, 2'd2, 3'd5, 1'b0};
    r = pre_off(op, T_RAS) + T_RP;
    start_req(0, op, a, h, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL default_ready_timeout op=%0d", op); end
    watch(0, r + 2, 1, 1'b0, 2'd0, 36'd0);
    pd = -1; rd = -1;
    for (int k = 1; k <= r + 2; k++) begin
      if (pd < 0 && rec_obs[k][29]) pd = k;
      if (rd < 0 && rec_obs[k][34]) rd = k;
      n_checks++;
      if (rec_obs[k] !== exp_obs(op, T_RAS, f, k)) begin
        n_fail++;
        $display("FAIL default_trace op=%0d k=%0d: got %h want %h", op, k, rec_obs[k],
                 exp_obs(op, T_RAS, f, k));
      end
    end
    n_checks++;
    if (rec_obs[1][27:0] !== f) begin
      n_fail++;
      $display("FAIL default_fields: got %h want %h", rec_obs[1][27:0], f);
    end
    n_checks++;
    if (pd !== pre_lit) begin
      n_fail++;
      $display("FAIL default_pre_offset op=%0d: got %0d want %0d", op, pd, pre_lit);
    end
    n_checks++;
    if (rd !== rdy_lit) begin
      n_fail++;
      $display("FAIL default_ready_offset op=%0d: got %0d want %0d", op, rd, rdy_lit);
    end
  endtask

  task automatic test_tras;
    logic [35:0] a;
    logic [27:0] f;
    int h, r, pd;
    bit ok;
    a = rand_addr();
    f = spec_fields(a);
    r = pre_off(2'd0, T_RAS2) + T_RP;
    start_req(1, 2'd0, a, h, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tras_ready_timeout"); end
    watch(1, r + 2, 1, 1'b0, 2'd0, 36'd0);
    pd = -1;
    for (int k = 1; k <= r + 2; k++) begin
      if (pd < 0 && rec_obs[k][29]) pd = k;
      n_checks++;
      if (rec_obs[k] !== exp_obs(2'd0, T_RAS2, f, k)) begin
        n_fail++;
        $display("FAIL tras_trace k=%0d: got %h want %h", k, rec_obs[k],
                 exp_obs(2'd0, T_RAS2, f, k));
      end
    end
    n_checks++;
    if (pd !== 121) begin
      n_fail++;
      $display("FAIL tras_pre_offset: got %0d want 121", pd);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) begin
      logic [1:0]  op;
      logic [35:0] a;
      logic [27:0] f;
      int h, r;
      bit ok;
      op = 2'($urandom_range(0, 2));
      a = rand_addr();
      f = spec_fields(a);
      r = pre_off(op, T_RAS) + T_RP;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_req(0, op, a, h, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL random_ready_timeout n=%0d", n); end
      watch(0, r + 1, 1, 1'b0, 2'd0, 36'd0);
      for (int k = 1; k <= r + 1; k++) begin
        n_checks++;
        if (rec_obs[k] !== exp_obs(op, T_RAS, f, k)) begin
          n_fail++;
          $display("FAIL random_trace n=%0d op=%0d k=%0d: got %h want %h", n, op, k,
                   rec_obs[k], exp_obs(op, T_RAS, f, k));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  op1, op2;
    logic [35:0] a1, a2;
    logic [27:0] f1, f2;
    logic [34:0] e;
    int h, r1, r2;
    bit ok;
    op1 = 2'($urandom_range(0, 2));
    op2 = 2'($urandom_range(0, 2));
    a1 = rand_addr();
    a2 = rand_addr();
    f1 = spec_fields(a1);
    f2 = spec_fields(a2);
    r1 = pre_off(op1, T_RAS) + T_RP;
    r2 = pre_off(op2, T_RAS) + T_RP;
    start_req(0, op1, a1, h, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_ready_timeout"); end
    // Valid stays high; the queue head changes to the second request meanwhile.
    watch(0, r1 + r2, r1 + 1, 1'b1, op2, a2);
    for (int k = 1; k <= r1 + r2; k++) begin
      e = (k <= r1) ? exp_obs(op1, T_RAS, f1, k) : exp_obs(op2, T_RAS, f2, k - r1);
      n_checks++;
      if (rec_obs[k] !== e) begin
        n_fail++;
        $display("FAIL b2b_trace k=%0d: got %h want %h", k, rec_obs[k], e);
      end
    end
  endtask

  task automatic test_illegal;
    logic [35:0] a;
    logic [27:0] f;
    logic [34:0] e;
    int h;
    bit ok;
    a = rand_addr();
    f = spec_fields(a);
    start_req(0, 2'd3, a, h, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL illegal_ready_timeout"); end
    watch(0, 4, 1, 1'b0, 2'd0, 36'd0);
    for (int k = 1; k <= 4; k++) begin
      e = {(k >= 2), 1'b0, 3'd0, 1'b0, (k == 1), f};
      n_checks++;
      if (rec_obs[k] !== e) begin
        n_fail++;
        $display("FAIL illegal_trace k=%0d: got %h want %h", k, rec_obs[k], e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [35:0] a;
    logic [27:0] f;
    int h, r;
    bit ok;
    a = rand_addr();
    a[11:6] = 6'h3F;
    f = spec_fields(a);
    start_req(0, 2'd0, a, h, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_ready_timeout"); end
    watch(0, 20, 1, 1'b0, 2'd0, 36'd0);
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if (rec_obs[k] !== exp_obs(2'd0, T_RAS, f, k)) begin
        n_fail++;
        $display("FAIL rstmid_pre_trace k=%0d: got %h want %h", k, rec_obs[k],
                 exp_obs(2'd0, T_RAS, f, k));
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs0 !== RESET_OBS) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h want %h", obs0, RESET_OBS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch(0, 150, 1, 1'b0, 2'd0, 36'd0);
    for (int k = 1; k <= 150; k++) begin
      n_checks++;
      if (rec_obs[k] !== RESET_OBS) begin
        n_fail++;
        $display("FAIL rstmid_abandoned k=%0d: got %h want %h", k, rec_obs[k], RESET_OBS);
      end
    end
    a = rand_addr();
    f = spec_fields(a);
    r = pre_off(2'd2, T_RAS) + T_RP;
    start_req(0, 2'd2, a, h, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_after_timeout"); end
    watch(0, r, 1, 1'b0, 2'd0, 36'd0);
    for (int k = 1; k <= r; k++) begin
      n_checks++;
      if (rec_obs[k] !== exp_obs(2'd2, T_RAS, f, k)) begin
        n_fail++;
        $display("FAIL rstmid_after_trace k=%0d: got %h want %h", k, rec_obs[k],
                 exp_obs(2'd2, T_RAS, f, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default(2'd0, 88, 127);
    test_default(2'd1, 86, 125);
    test_tras();
    test_random();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
